// File: rtl/frame_diff_detect_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_diff_detect_if
// Description : Video pixel stream bundle (pixel valid, frame sync, line
//               active, pixel data). The producer uses the master modport,
//               the consumer uses the slave modport.
//               Signals: clken  - pixel valid
//                        vsync  - frame sync
//                        href   - line active
//                        data   - pixel payload, DATA_W bits
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_diff_detect_if #(
    parameter int DATA_W = 16
) ();
    logic              clken;
    logic              vsync;
    logic              href;
    logic [DATA_W-1:0] data;

    modport master (output clken, output vsync, output href, output data);
    modport slave  (input  clken, input  vsync, input  href, input  data);
endinterface
`default_nettype wire

// File: rtl/frame_diff_detect.sv
`default_nettype none
// ============================================================================
// Module      : frame_diff_detect
// Description : Frame-difference motion detector. Takes the packed
//               {current, previous} gray stream, forms |cur - prev|,
//               binarises it against a per-frame threshold and forwards a
//               binary motion stream two cycles later. Per frame it counts
//               motion pixels and tracks their bounding box, publishing the
//               statistics on each frame boundary.
// Ports       : clk, rst_n          - pixel clock, async active-low reset
//               ajct  (slave)       - input stream, data = {cur, prev}
//               threshold           - binarisation threshold
//               diff  (master)      - output stream, data = 8'hFF / 8'h00
//               motion_cnt          - motion pixels in last published frame
//               box_x/y_min/max     - bounding box of motion pixels
//               box_valid           - last frame had at least one motion px
//               motion_flag         - motion_cnt >= MIN_PIXELS
//               frame_done          - 1-cycle pulse on statistics update
// Revision    : 1.0 - initial release
// ============================================================================
module frame_diff_detect #(
    parameter int IMG_H_DISP = 640,
    parameter int IMG_V_DISP = 480,
    parameter int CNT_W      = 19,
    parameter int MIN_PIXELS = 64
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    frame_diff_detect_if.slave     ajct,
    input  wire logic [7:0]        threshold,
    frame_diff_detect_if.master    diff,
    output logic [CNT_W-1:0]       motion_cnt,
    output logic [9:0]             box_x_min,
    output logic [9:0]             box_x_max,
    output logic [9:0]             box_y_min,
    output logic [9:0]             box_y_max,
    output logic                   box_valid,
    output logic                   motion_flag,
    output logic                   frame_done
);
    localparam logic [9:0]       c_X_LAST     = 10'(IMG_H_DISP - 1);
    localparam logic [9:0]       c_Y_LAST     = 10'(IMG_V_DISP - 1);
    localparam logic [CNT_W-1:0] c_MIN_PIXELS = CNT_W'(MIN_PIXELS);

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic [8:0] w_sub;
    logic [7:0] w_abs;

    // 9-bit subtract keeps the sign; a negative result is negated back.
    assign w_sub = {1'b0, ajct.data[15:8]} - {1'b0, ajct.data[7:0]};
    assign w_abs = w_sub[8] ? (~w_sub[7:0] + 8'd1) : w_sub[7:0];

    logic       r_ck1, r_vs1, r_hs1;
    logic [7:0] r_diff;
    logic       r_ck2, r_vs2, r_hs2;
    logic [7:0] r_bin;
    logic       r_vs3, r_hs3;
    logic [7:0] r_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ck1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_hs1  <= 1'b0;
            r_diff <= 8'd0;
            r_ck2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_hs2  <= 1'b0;
            r_bin  <= 8'd0;
            r_vs3  <= 1'b0;
            r_hs3  <= 1'b0;
        end else begin
            r_ck1  <= ajct.clken;
            r_vs1  <= ajct.vsync;
            r_hs1  <= ajct.href;
            r_diff <= w_abs;
            r_ck2  <= r_ck1;
            r_vs2  <= r_vs1;
            r_hs2  <= r_hs1;
            // Strict compare: a difference equal to the threshold is static.
            r_bin  <= (r_diff > r_thr) ? 8'hFF : 8'h00;
            r_vs3  <= r_vs2;
            r_hs3  <= r_hs2;
        end
    end

    assign diff.clken = r_ck2;
    assign diff.vsync = r_vs2;
    assign diff.href  = r_hs2;
    assign diff.data  = r_bin;

    logic w_vs_rise, w_hs_fall, w_pix, w_motion, w_in_box;

    assign w_vs_rise = r_vs2 & ~r_vs3;
    assign w_hs_fall = r_hs3 & ~r_hs2;
    assign w_pix     = r_hs2 & r_ck2;
    // Pixels seen while sync is still high are not attributed to any frame.
    assign w_motion  = w_pix & ~r_vs2 & (r_bin == 8'hFF);

    // ------------------------------------------------------------------
    // Coordinate counters
    // ------------------------------------------------------------------
    logic [9:0] r_x, r_y;
    logic       r_x_ovf;   // a pixel was already taken at the last column

    assign w_in_box = w_motion & ~r_x_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_x_ovf <= 1'b0;
        end else if (w_vs_rise) begin
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_x_ovf <= 1'b0;
        end else if (w_hs_fall) begin
            r_x     <= 10'd0;
            r_x_ovf <= 1'b0;
            if (r_y != c_Y_LAST) begin
                r_y <= r_y + 10'd1;
            end
        end else if (w_pix) begin
            if (r_x != c_X_LAST) begin
                r_x <= r_x + 10'd1;
            end else begin
                r_x_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-frame accumulators
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_acc_cnt;
    logic [9:0]       r_x_min, r_x_max, r_y_min, r_y_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
            r_x_min   <= '1;
            r_x_max   <= '0;
            r_y_min   <= '1;
            r_y_max   <= '0;
        end else if (w_vs_rise) begin
            r_acc_cnt <= '0;
            r_x_min   <= '1;
            r_x_max   <= '0;
            r_y_min   <= '1;
            r_y_max   <= '0;
        end else if (w_motion) begin
            if (r_acc_cnt != '1) begin
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end
            if (w_in_box) begin
                if (r_x < r_x_min) r_x_min <= r_x;
                if (r_x > r_x_max) r_x_max <= r_x;
                if (r_y < r_y_min) r_y_min <= r_y;
                if (r_y > r_y_max) r_y_max <= r_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame boundary: threshold latch and statistics publish
    // ------------------------------------------------------------------
    logic [1:0] r_frame_cnt;
    logic       w_any;

    assign w_any = (r_acc_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr       <= 8'd0;
            r_frame_cnt <= 2'd0;
            motion_cnt  <= '0;
            box_x_min   <= 10'd0;
            box_x_max   <= 10'd0;
            box_y_min   <= 10'd0;
            box_y_max   <= 10'd0;
            box_valid   <= 1'b0;
            motion_flag <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_vs_rise) begin
                r_thr <= threshold;
                if (r_frame_cnt != 2'd2) begin
                    r_frame_cnt <= r_frame_cnt + 2'd1;
                end
                // The first boundary after reset closes a frame built from a
                // stale previous-frame read, so it is not published.
                if (r_frame_cnt != 2'd0) begin
                    motion_cnt  <= r_acc_cnt;
                    box_valid   <= w_any;
                    box_x_min   <= w_any ? r_x_min : 10'd0;
                    box_x_max   <= w_any ? r_x_max : 10'd0;
                    box_y_min   <= w_any ? r_y_min : 10'd0;
                    box_y_max   <= w_any ? r_y_max : 10'd0;
                    motion_flag <= (r_acc_cnt >= c_MIN_PIXELS);
                    frame_done  <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_frame_diff_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_diff_detect
// Description : Directed self-checking bench for frame_diff_detect on an
//               8x4 image with MIN_PIXELS = 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_diff_detect;
    localparam int c_W = 8;
    localparam int c_H = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  threshold;
    logic [18:0] motion_cnt;
    logic [9:0]  box_x_min, box_x_max, box_y_min, box_y_max;
    logic        box_valid, motion_flag, frame_done;

    frame_diff_detect_if #(.DATA_W(16)) ajct_if ();
    frame_diff_detect_if #(.DATA_W(8))  diff_if ();

    frame_diff_detect #(
        .IMG_H_DISP (c_W),
        .IMG_V_DISP (c_H),
        .CNT_W      (19),
        .MIN_PIXELS (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ajct        (ajct_if),
        .threshold   (threshold),
        .diff        (diff_if),
        .motion_cnt  (motion_cnt),
        .box_x_min   (box_x_min),
        .box_x_max   (box_x_max),
        .box_y_min   (box_y_min),
        .box_y_max   (box_y_max),
        .box_valid   (box_valid),
        .motion_flag (motion_flag),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [7:0] cur_img [c_W*c_H];
    logic [7:0] prv_img [c_W*c_H];

    task automatic clear_img(input logic [7:0] c, input logic [7:0] p);
        for (int i = 0; i < c_W*c_H; i++) begin
            cur_img[i] = c;
            prv_img[i] = p;
        end
    endtask

    task automatic set_px(input int x, input int y, input logic [7:0] c, input logic [7:0] p);
        cur_img[y*c_W + x] = c;
        prv_img[y*c_W + x] = p;
    endtask

    task automatic drive(input logic vs, input logic hs, input logic ck, input logic [15:0] g);
        @(negedge clk);
        ajct_if.vsync = vs;
        ajct_if.href  = hs;
        ajct_if.clken = ck;
        ajct_if.data  = g;
    endtask

    task automatic send_rows(input int lo, input int hi);
        for (int y = lo; y <= hi; y++) begin
            for (int x = 0; x < c_W; x++) begin
                drive(1'b0, 1'b1, 1'b1, {cur_img[y*c_W + x], prv_img[y*c_W + x]});
            end
            repeat (3) drive(1'b0, 1'b0, 1'b0, 16'd0);
        end
    endtask

    task automatic send_vsync();
        repeat (3) drive(1'b1, 1'b0, 1'b0, 16'd0);
        repeat (6) drive(1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic check_stats(input string tag, input int cnt, input int xmin, input int xmax,
                               input int ymin, input int ymax, input logic valid, input logic flag);
        check({tag, "_cnt"},   32'(motion_cnt),  32'(cnt));
        check({tag, "_xmin"},  32'(box_x_min),   32'(xmin));
        check({tag, "_xmax"},  32'(box_x_max),   32'(xmax));
        check({tag, "_ymin"},  32'(box_y_min),   32'(ymin));
        check({tag, "_ymax"},  32'(box_y_max),   32'(ymax));
        check({tag, "_valid"}, 32'(box_valid),   32'(valid));
        check({tag, "_flag"},  32'(motion_flag), 32'(flag));
    endtask

    int d0;

    initial begin
        rst_n         = 1'b0;
        threshold     = 8'd10;
        ajct_if.vsync = 1'b0;
        ajct_if.href  = 1'b0;
        ajct_if.clken = 1'b0;
        ajct_if.data  = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cnt",   32'(motion_cnt),     32'd0);
        check("rst_valid", 32'(box_valid),      32'd0);
        check("rst_flag",  32'(motion_flag),    32'd0);
        check("rst_done",  32'(frame_done),     32'd0);
        check("rst_clken", 32'(diff_if.clken),  32'd0);
        check("rst_bin",   32'(diff_if.data),   32'd0);
        rst_n = 1'b1;

        // Frame 1: full motion, closed by the first boundary -> suppressed
        clear_img(8'd100, 8'd20);
        send_rows(0, c_H-1);
        send_vsync();
        check("f1_done", 32'(done_cnt), 32'd0);
        check("f1_cnt",  32'(motion_cnt), 32'd0);
        check("f1_valid", 32'(box_valid), 32'd0);

        // Frame 2: identical cur/prev -> no motion, published
        clear_img(8'd77, 8'd77);
        send_rows(0, c_H-1);
        send_vsync();
        check("f2_done", 32'(done_cnt), 32'd1);
        check_stats("f2", 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // Frame 3: three motion pixels, count reaches MIN_PIXELS
        clear_img(8'd77, 8'd77);
        set_px(2, 1, 8'd100, 8'd20);
        set_px(5, 1, 8'd100, 8'd20);
        set_px(3, 3, 8'd100, 8'd20);
        send_rows(0, c_H-1);
        send_vsync();
        check("f3_done", 32'(done_cnt), 32'd2);
        check_stats("f3", 3, 2, 5, 1, 3, 1'b1, 1'b1);

        // Frame 4: latency and strict-threshold boundary
        drive(1'b0, 1'b1, 1'b1, {8'd50, 8'd40});
        drive(1'b0, 1'b1, 1'b1, {8'd40, 8'd51});
        check("lat_1cyc_clken", 32'(diff_if.clken), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 16'd0);
        check("lat_p0_clken", 32'(diff_if.clken), 32'd1);
        check("lat_p0_bin",   32'(diff_if.data),  32'h00);
        drive(1'b0, 1'b0, 1'b0, 16'd0);
        check("lat_p1_clken", 32'(diff_if.clken), 32'd1);
        check("lat_p1_bin",   32'(diff_if.data),  32'hFF);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 16'd0);
        send_vsync();
        check("f4_done", 32'(done_cnt), 32'd3);
        check_stats("f4", 1, 1, 1, 0, 0, 1'b1, 1'b0);

        // Frame 5: threshold raised mid-frame, still 10 for this frame
        clear_img(8'd77, 8'd77);
        set_px(0, 0, 8'd100, 8'd20);
        set_px(4, 2, 8'd100, 8'd20);
        send_rows(0, 1);
        threshold = 8'd200;
        send_rows(2, c_H-1);
        send_vsync();
        check_stats("f5", 2, 0, 4, 0, 2, 1'b1, 1'b0);

        // Frame 6: threshold now 200; diff 80 static, 250 motion, 200 static
        clear_img(8'd77, 8'd77);
        set_px(3, 0, 8'd100, 8'd20);
        set_px(1, 1, 8'd5,   8'd255);
        set_px(6, 2, 8'd255, 8'd5);
        set_px(2, 3, 8'd0,   8'd200);
        send_rows(0, c_H-1);
        send_vsync();
        check("f6_done", 32'(done_cnt), 32'd5);
        check_stats("f6", 2, 1, 6, 1, 2, 1'b1, 1'b0);

        // Frame 7: reset mid-frame
        clear_img(8'd100, 8'd20);
        send_rows(0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_cnt",  32'(motion_cnt), 32'd0);
        check("mrst_valid", 32'(box_valid), 32'd0);
        check("mrst_xmax", 32'(box_x_max),  32'd0);
        check("mrst_ymax", 32'(box_y_max),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        threshold = 8'd10;
        d0 = done_cnt;
        send_rows(2, c_H-1);
        send_vsync();
        check("f7_suppressed", 32'(done_cnt - d0), 32'd0);
        check("f7_cnt", 32'(motion_cnt), 32'd0);

        // Frame 8: published normally after the suppressed frame
        clear_img(8'd77, 8'd77);
        set_px(0, 0, 8'd100, 8'd20);
        set_px(7, 3, 8'd100, 8'd20);
        set_px(4, 2, 8'd100, 8'd20);
        send_rows(0, c_H-1);
        send_vsync();
        check("f8_done", 32'(done_cnt - d0), 32'd1);
        check_stats("f8", 3, 0, 7, 0, 3, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
